// File: rtl/ps2_pkg.sv
// ps2_pkg: constants shared by the PS/2 receiver and the key-decoding stage.
//   PS2_FRAME_BITS : bits per device-to-host frame (start, 8 data, parity, stop)
//   PS2_BREAK      : key-release prefix byte
//   PS2_EXT        : extended-key prefix byte
//   frame_ok()     : start/stop/odd-parity check on a captured frame
package ps2_pkg;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;

  // Bit counter value at which the incoming bit is the stop bit.
  localparam logic [3:0] CNT_STOP = 4'd10;

  // Frame layout (index 0 arrives first):
  //   [0] start, [8:1] D0..D7, [9] odd parity, [10] stop.
  // Odd parity means the XOR of data and parity bits is 1.
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: byte queue between the frame receiver and the key handler.
//   clk, clrn : clock, synchronous active-low reset (clears pointers and mem)
//   push      : write wdata this cycle (ignored when full unless popping)
//   pop       : advance the head this cycle (ignored when empty)
//   wdata     : byte to write
//   head      : byte at the queue head (combinational read)
//   full      : no free entry
//   empty     : no stored entry
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// When full, a push in the same cycle as a pop is accepted.
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: PS/2 device-to-host receiver with byte queue.
//   clk        : system clock
//   clrn       : synchronous active-low reset
//   ps2_clk    : raw PS/2 clock pin (async, idle high)
//   ps2_data   : raw PS/2 data pin (async, idle high)
//   nextdata_n : active-low pop request, one cycle per byte
//   data       : queue head, valid while ready=1
//   ready      : queue non-empty
//   overflow   : sticky, a valid byte was dropped on a full queue
//   frame_err  : one-cycle pulse per rejected or timed-out frame
// Handshake: the consumer reads data while ready=1 and drives nextdata_n low
// for one cycle to consume it; the next byte (or ready=0) appears right after
// that edge. Pops while empty are ignored.
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Two-flop synchronisers; clk_prev is the extra flop for edge detection.
  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  logic [3:0]                cnt;
  logic [PS2_FRAME_BITS-1:0] shreg;
  logic [PS2_FRAME_BITS-1:0] frame_next;
  logic [WD_W-1:0]           wd;

  logic at_stop;
  logic good;
  logic timeout;
  logic pop;
  logic push;
  logic drop;
  logic full;
  logic empty;

  assign fall = clk_prev & ~clk_s2;

  // Bits shift in from the top so the first-received start bit ends in [0].
  assign frame_next = {dat_s2, shreg[PS2_FRAME_BITS-1:1]};

  assign at_stop = fall && (cnt == CNT_STOP);
  assign good    = frame_ok(frame_next);
  assign timeout = (cnt != 4'd0) && !fall && (wd == WD_LAST);

  assign pop   = !nextdata_n && !empty;
  assign push  = at_stop && good && (!full || pop);
  assign drop  = at_stop && good && full && !pop;
  assign ready = !empty;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_prev  <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      cnt       <= 4'd0;
      shreg     <= '0;
      wd        <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;

      if (fall) begin
        shreg <= frame_next;
        cnt   <= at_stop ? 4'd0 : cnt + 4'd1;
        wd    <= '0;
      end else if (cnt == 4'd0) begin
        wd <= '0;
      end else if (timeout) begin
        // Truncated frame: discard and wait for the next start bit.
        cnt <= 4'd0;
        wd  <= '0;
      end else begin
        wd <= wd + 1'b1;
      end

      frame_err <= (at_stop && !good) || timeout;
      overflow  <= overflow | drop;
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .pop   (pop),
    .wdata (frame_next[8:1]),
    .head  (data),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_ps2_frame_receiver.sv
module tb_ps2_frame_receiver;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 300;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_frame_receiver #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       exp_ovf;
  int         n_pass  = 0;
  int         n_total = 0;

  // frame_err pulse monitor, sampled mid-cycle
  int   err_cnt  = 0;
  int   err_wide = 0;
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (frame_err === 1'b1 && err_prev === 1'b1) err_wide++;
    err_prev = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par,
                                             input bit bad_stop);
    logic par;
    par = ~(^d) ^ bad_par;
    return {~bad_stop, par, d, 1'b0};
  endfunction

  task automatic check_head(input string tag);
    check({tag, "_ready"}, ready, (exp_q.size() > 0));
    if (exp_q.size() > 0) check({tag, "_data"}, data, exp_q[0]);
    check({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(half);
      ps2_clk = 1'b0;
      cyc(half);
      ps2_clk = 1'b1;
    end
  endtask

  // Full frame; the stop-bit fall is followed edge by edge to check push timing.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input bit pop_at_push, input int half);
    logic [10:0] f;
    bit          valid;
    bit          popped;
    int          e0;
    f     = make_frame(d, bad_par, bad_stop);
    valid = !bad_par && !bad_stop;
    e0    = err_cnt;
    send_bits(f, 10, half);
    ps2_data = f[10];
    cyc(half);
    ps2_clk = 1'b0;
    cyc(2);
    check_head("pre_push");
    check("pre_push_err", frame_err, 1'b0);
    if (pop_at_push) nextdata_n = 1'b0;
    cyc(1);
    nextdata_n = 1'b1;
    popped = pop_at_push && (exp_q.size() > 0);
    if (popped) void'(exp_q.pop_front());
    if (valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end
    check_head("post_push");
    check("post_push_err", frame_err, !valid);
    cyc(half - 3);
    ps2_clk = 1'b1;
    cyc(half);
    check("frame_err_count", err_cnt - e0, valid ? 0 : 1);
  endtask

  task automatic pop_one();
    check_head("pre_pop");
    nextdata_n = 1'b0;
    cyc(1);
    nextdata_n = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check_head("post_pop");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int e0;
    clrn       = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    exp_ovf    = 1'b0;
    cyc(3);
    check("rst_ready", ready, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_ovf", overflow, 1'b0);
    check("rst_err", frame_err, 1'b0);
    clrn = 1'b1;

    // idle pins after reset
    e0 = err_cnt;
    cyc(1000);
    check("idle_err", err_cnt - e0, 0);
    check("idle_ready", ready, 1'b0);
    check("idle_data", data, 8'h00);
    check("idle_ovf", overflow, 1'b0);

    // single frame 0x1C and pop
    send_frame(8'h1C, 0, 0, 0, 6);
    pop_one();

    // back-to-back F0, 1C
    send_frame(8'hF0, 0, 0, 0, 5);
    send_frame(8'h1C, 0, 0, 0, 5);
    pop_one();
    pop_one();
    pop_one();  // pop while empty is ignored

    // bad parity, bad stop
    send_frame(8'h5A, 1, 0, 0, 6);
    send_frame(8'h12, 0, 1, 0, 6);
    check("bad_frames_ready", ready, 1'b0);

    // overflow: 9 frames into depth 8
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, 4);
    check("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) pop_one();
    // fill, then pop in the push cycle of a 9th frame
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 0, 0, 0, 4);
    send_frame(8'hA7, 0, 0, 1, 4);
    for (int i = 0; i < DEPTH; i++) pop_one();

    // randomised frames and pops
    for (int i = 0; i < 30; i++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 $urandom_range(4, 8));
      if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) pop_one();
    end
    while (exp_q.size() > 0) pop_one();

    // truncated frame -> watchdog
    e0 = err_cnt;
    send_bits(make_frame(8'h33, 0, 0), 5, 5);
    cyc(TIMEOUT - 10);
    check("timeout_early", err_cnt - e0, 0);
    cyc(40);
    check("timeout_pulse", err_cnt - e0, 1);
    check_head("timeout_q");
    send_frame(8'h29, 0, 0, 0, 6);
    check_head("after_timeout");

    // reset mid-frame with a byte queued and overflow set
    send_frame(8'h66, 0, 0, 0, 5);
    send_bits(make_frame(8'h77, 0, 0), 4, 5);
    clrn = 1'b0;
    cyc(1);
    check("midrst_ready", ready, 1'b0);
    check("midrst_data", data, 8'h00);
    check("midrst_ovf", overflow, 1'b0);
    check("midrst_err", frame_err, 1'b0);
    clrn = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    cyc(20);
    send_frame(8'h45, 0, 0, 0, 6);
    pop_one();

    check("err_pulse_width", err_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
